data_mem_ctrl: RTL and testbench

Data-memory controller on the processor's data port, directly downstream of the MemoryStart/MemoryWait stages. It accepts load/store requests and holds a DEPTH-word internal RAM. Read data and DataDone are returned after a configurable number of wait states. DataDone low is the processor's stall condition. A side-band load port preloads memory for benches and boot.

---
 rtl/data_mem_ctrl_pkg.sv | 16 +
 rtl/data_ram.sv | 35 +++
 rtl/data_mem_ctrl.sv | 94 +++++++++
 tb/tb_data_mem_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Processor-wide shared definitions: data word width and memory-port state encoding.
package data_mem_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } MemState;

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM with a side-band preload write port and a registered read.
module data_ram #(
  parameter int WORD_SIZE = data_mem_ctrl_pkg::WORD_SIZE,
  parameter int DEPTH     = 256
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  input  logic                         store_en,
  input  logic [WORD_SIZE-1:0]         store_data,
  input  logic                         read_en,
  output logic [WORD_SIZE-1:0]         read_data,
  input  logic                         preload_en,
  input  logic [$clog2(DEPTH)-1:0]     preload_addr,
  input  logic [WORD_SIZE-1:0]         preload_data
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Store is written last so it overrides a preload to the same index.
  always_ff @(posedge Clock) begin
    if (preload_en)
      mem[preload_addr] <= preload_data;
    if (store_en)
      mem[addr] <= store_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      read_data <= '0;
    else if (read_en)
      read_data <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-port memory controller: accepts loads/stores, inserts wait states, flags bad requests.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = data_mem_ctrl_pkg::WORD_SIZE,
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = $clog2(DEPTH),
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [WORD_SIZE-1:0]  DataAddr,
  input  logic [WORD_SIZE-1:0]  DataOut,
  input  logic                  ReadData,
  input  logic                  WriteData,
  input  logic                  LoadEn,
  input  logic [ADDR_BITS-1:0]  LoadAddr,
  input  logic [WORD_SIZE-1:0]  LoadData,
  output logic [WORD_SIZE-1:0]  DataIn,
  output logic                  DataDone,
  output logic                  ReqErr
);

  localparam int CNT_BITS = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  MemState               state;
  logic [CNT_BITS-1:0]   wait_cnt;
  logic                  req;
  logic                  accept;
  logic                  is_store;
  logic                  is_load;
  logic                  addr_high;
  logic                  bad_req;
  logic [ADDR_BITS-1:0]  index;

  assign req       = ReadData | WriteData;
  assign DataDone  = (state != WAIT);
  assign accept    = DataDone & req;
  assign is_store  = accept & WriteData;
  assign is_load   = accept & ReadData & ~WriteData;
  assign index     = DataAddr[ADDR_BITS-1:0];
  assign addr_high = (DataAddr >> ADDR_BITS) != '0;
  assign bad_req   = (ReadData & WriteData) | addr_high;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ReqErr   <= 1'b0;
    end else begin
      if (accept && bad_req)
        ReqErr <= 1'b1;
      case (state)
        // RESP behaves like IDLE so a held request is accepted back-to-back.
        IDLE, RESP: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_BITS'(WAIT_STATES - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == '0)
            state <= RESP;
          else
            wait_cnt <= wait_cnt - CNT_BITS'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  data_ram #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_ram (
    .Clock        (Clock),
    .Reset        (Reset),
    .addr         (index),
    .store_en     (is_store),
    .store_data   (DataOut),
    .read_en      (is_load),
    .read_data    (DataIn),
    .preload_en   (LoadEn),
    .preload_addr (LoadAddr),
    .preload_data (LoadData)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with two instances: two wait states and zero wait states.
module tb_data_mem_ctrl;

  localparam int W  = 16;
  localparam int D  = 256;
  localparam int AB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]  a_addr, a_dout, a_din, a_ld;
  logic          a_rd, a_wr, a_le, a_done, a_err;
  logic [AB-1:0] a_la;
  logic [W-1:0]  b_addr, b_dout, b_din, b_ld;
  logic          b_rd, b_wr, b_le, b_done, b_err;
  logic [AB-1:0] b_la;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;

  data_mem_ctrl #(.WORD_SIZE(W), .DEPTH(D), .ADDR_BITS(AB), .WAIT_STATES(2)) u_ws2 (
    .Clock(clk), .Reset(rst), .DataAddr(a_addr), .DataOut(a_dout), .ReadData(a_rd),
    .WriteData(a_wr), .LoadEn(a_le), .LoadAddr(a_la), .LoadData(a_ld),
    .DataIn(a_din), .DataDone(a_done), .ReqErr(a_err));

  data_mem_ctrl #(.WORD_SIZE(W), .DEPTH(D), .ADDR_BITS(AB), .WAIT_STATES(0)) u_ws0 (
    .Clock(clk), .Reset(rst), .DataAddr(b_addr), .DataOut(b_dout), .ReadData(b_rd),
    .WriteData(b_wr), .LoadEn(b_le), .LoadAddr(b_la), .LoadData(b_ld),
    .DataIn(b_din), .DataDone(b_done), .ReqErr(b_err));

  task automatic a_preload(input logic [AB-1:0] ad, input logic [W-1:0] d);
    @(negedge clk); a_le = 1'b1; a_la = ad; a_ld = d;
    @(negedge clk); a_le = 1'b0;
  endtask

  task automatic a_wait_done(input string name);
    int n = 0;
    while (a_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: DataDone=%b, required 1 within 20 cycles", name, a_done);
    end
  endtask

  // One request for one edge, then wait for the response cycle.
  task automatic a_issue(input logic rd, input logic wr, input logic [W-1:0] ad,
                         input logic [W-1:0] d, input string name);
    @(negedge clk); a_rd = rd; a_wr = wr; a_addr = ad; a_dout = d;
    @(negedge clk); a_rd = 1'b0; a_wr = 1'b0;
    a_wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_le = 0; a_addr = '0; a_dout = '0; a_la = '0; a_ld = '0;
    b_rd = 0; b_wr = 0; b_le = 0; b_addr = '0; b_dout = '0; b_la = '0; b_ld = '0;
    #3;
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rst_a_done: got %b want 1", a_done); end
    checks++; if (a_din !== 16'h0) begin errors++; $display("FAIL rst_a_din: got %h want 0000", a_din); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_a_err: got %b want 0", a_err); end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL rst_b_done: got %b want 1", b_done); end
    checks++; if (b_din !== 16'h0) begin errors++; $display("FAIL rst_b_din: got %h want 0000", b_din); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL rst_b_err: got %b want 0", b_err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wait_states();
    a_preload(8'd5, 16'h1234);
    a_preload(8'd6, 16'h0066);
    a_preload(8'd7, 16'h7777);
    a_preload(8'd10, 16'h1010);
    a_preload(8'd20, 16'h2020);
    @(negedge clk); a_rd = 1'b1; a_addr = 16'd5; exp_q.push_back(16'h1234);
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ws_n1_done: got %b want 0", a_done); end
    a_addr = 16'd7;
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ws_n2_done: got %b want 0", a_done); end
    a_rd = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ws_n3_done: got %b want 1", a_done); end
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL ws_n3_data: got %h want %h", a_din, exp); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ws_idle_done: got %b want 1", a_done); end
    checks++; if (a_din !== 16'h1234) begin errors++; $display("FAIL ws_wait_ignored: got %h want 1234", a_din); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); a_rd = 1'b1; a_addr = 16'd5; exp_q.push_back(16'h1234);
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_n1_done: got %b want 0", a_done); end
    a_addr = 16'd6; exp_q.push_back(16'h0066);
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_n2_done: got %b want 0", a_done); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_n3_done: got %b want 1", a_done); end
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL b2b_first_data: got %h want %h", a_din, exp); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_resp_accept: got %b want 0", a_done); end
    a_rd = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_n5_done: got %b want 0", a_done); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_n6_done: got %b want 1", a_done); end
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL b2b_second_data: got %h want %h", a_din, exp); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_no_third: got %b want 1", a_done); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk); b_wr = 1'b1; b_addr = 16'd9; b_dout = 16'hBEEF;
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL zw_store_done: got %b want 1", b_done); end
    b_wr = 1'b0; b_rd = 1'b1; exp_q.push_back(16'hBEEF);
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL zw_load_done: got %b want 1", b_done); end
    exp = exp_q.pop_front();
    checks++; if (b_din !== exp) begin errors++; $display("FAIL zw_load_data: got %h want %h", b_din, exp); end
    b_rd = 1'b0;
  endtask

  task automatic test_both_high();
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", a_err); end
    a_issue(1'b1, 1'b1, 16'h0103, 16'd7, "both_wait");
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", a_err); end
    checks++; if (a_din !== 16'h0066) begin errors++; $display("FAIL both_no_read: got %h want 0066", a_din); end
    exp_q.push_back(16'd7);
    a_issue(1'b1, 1'b0, 16'd3, 16'd0, "alias_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL alias_store: got %h want %h", a_din, exp); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", a_err); end
  endtask

  task automatic test_preload_collision();
    @(negedge clk);
    a_le = 1'b1; a_la = 8'd4; a_ld = 16'd1;
    a_wr = 1'b1; a_addr = 16'd4; a_dout = 16'd2;
    @(negedge clk); a_le = 1'b0; a_wr = 1'b0;
    a_wait_done("coll_store_wait");
    exp_q.push_back(16'd2);
    a_issue(1'b1, 1'b0, 16'd4, 16'd0, "coll_rd4_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL coll_store_wins: got %h want %h", a_din, exp); end
    @(negedge clk);
    a_le = 1'b1; a_la = 8'd10; a_ld = 16'hAAAA;
    a_rd = 1'b1; a_addr = 16'd10; exp_q.push_back(16'h1010);
    @(negedge clk); a_le = 1'b0; a_rd = 1'b0;
    a_wait_done("coll_load_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL coll_load_old: got %h want %h", a_din, exp); end
    exp_q.push_back(16'hAAAA);
    a_issue(1'b1, 1'b0, 16'd10, 16'd0, "coll_rd10_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL coll_preload_after: got %h want %h", a_din, exp); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); a_wr = 1'b1; a_addr = 16'd30; a_dout = 16'h3030;
    @(negedge clk); a_wr = 1'b0;
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL mid_in_wait: got %b want 0", a_done); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL mid_rst_done: got %b want 1", a_done); end
    checks++; if (a_din !== 16'h0) begin errors++; $display("FAIL mid_rst_din: got %h want 0000", a_din); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", a_err); end
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(16'h2020);
    a_issue(1'b1, 1'b0, 16'd20, 16'd0, "mid_rd20_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL mid_preload_kept: got %h want %h", a_din, exp); end
    exp_q.push_back(16'h3030);
    a_issue(1'b1, 1'b0, 16'd30, 16'd0, "mid_rd30_wait");
    exp = exp_q.pop_front();
    checks++; if (a_din !== exp) begin errors++; $display("FAIL mid_store_kept: got %h want %h", a_din, exp); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_back_to_back();
    test_zero_wait();
    test_both_high();
    test_preload_collision();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
